sdram_arbiter_2: RTL and testbench

SDRAM_ARBITER_2 -- requirements
Module: sdram_arbiter_2

---
 rtl/sdram_arbiter_2.sv | 110 +++++++++++
 tb/tb_sdram_arbiter_2.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_2.sv
// Two-master round-robin arbiter in front of a single-request SDRAM controller port.
// A master is granted in IDLE, served in BUSY and released once the controller drops its ack.
module sdram_arbiter_2 #(
    parameter int ADDRESS_WIDTH = 23
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [ADDRESS_WIDTH-1:0] m0_address,
    input  logic [31:0]              m0_data_in,
    input  logic [3:0]               m0_nwr,
    input  logic                     m0_req,
    output logic [31:0]              m0_data_out,
    output logic                     m0_ack,
    input  logic [ADDRESS_WIDTH-1:0] m1_address,
    input  logic [31:0]              m1_data_in,
    input  logic [3:0]               m1_nwr,
    input  logic                     m1_req,
    output logic [31:0]              m1_data_out,
    output logic                     m1_ack,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [31:0]              mem_data_out,
    output logic [3:0]               mem_nwr,
    output logic                     mem_req,
    input  logic [31:0]              mem_data_in,
    input  logic                     mem_ack
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant;
    logic   last_grant;
    logic   m0_elig, m1_elig;
    logic   do_grant, grant_sel, do_complete;

    // A master whose ack is still up has not yet seen its completion and must not be re-served.
    assign m0_elig = m0_req && !m0_ack;
    assign m1_elig = m1_req && !m1_ack;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m0_elig || m1_elig) state_nxt = BUSY;
            BUSY:    if (mem_ack)            state_nxt = RELEASE;
            RELEASE: if (!mem_ack)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        do_grant    = (state == IDLE) && (m0_elig || m1_elig);
        grant_sel   = (m0_elig && m1_elig) ? !last_grant : m1_elig;
        do_complete = (state == BUSY) && mem_ack;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem_address  <= '0;
            mem_data_out <= '0;
            mem_nwr      <= 4'b1111;
            mem_req      <= 1'b0;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            m0_data_out  <= '0;
            m1_data_out  <= '0;
        end else begin
            if (do_grant) begin
                mem_address  <= grant_sel ? m1_address : m0_address;
                mem_data_out <= grant_sel ? m1_data_in : m0_data_in;
                mem_nwr      <= grant_sel ? m1_nwr     : m0_nwr;
                mem_req      <= 1'b1;
                grant        <= grant_sel;
                last_grant   <= grant_sel;
            end
            if (do_complete) begin
                mem_req <= 1'b0;
                if (mem_nwr == 4'b1111) begin
                    if (grant) m1_data_out <= mem_data_in;
                    else       m0_data_out <= mem_data_in;
                end
            end
        end
    end

    // Completion wins over the clear so a master that dropped req mid-access still sees one ack cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
        end else begin
            if (do_complete && !grant) m0_ack <= 1'b1;
            else if (!m0_req)          m0_ack <= 1'b0;
            if (do_complete && grant)  m1_ack <= 1'b1;
            else if (!m1_req)          m1_ack <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter_2.sv
// Randomised bench for sdram_arbiter_2: controller model logs every access and a
// round-robin reference model predicts the order and content of those accesses.
module tb_sdram_arbiter_2;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          nreset = 1'b1;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [31:0]   m0_data_in = '0, m1_data_in = '0;
    logic [3:0]    m0_nwr = 4'hF, m1_nwr = 4'hF;
    logic          m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0]   m0_data_out, m1_data_out;
    logic          m0_ack, m1_ack;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data_out;
    logic [3:0]    mem_nwr;
    logic          mem_req;
    logic [31:0]   mem_data_in = '0;
    logic          mem_ack = 1'b0;

    sdram_arbiter_2 #(.ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .nreset(nreset),
        .m0_address(m0_address), .m0_data_in(m0_data_in), .m0_nwr(m0_nwr), .m0_req(m0_req),
        .m0_data_out(m0_data_out), .m0_ack(m0_ack),
        .m1_address(m1_address), .m1_data_in(m1_data_in), .m1_nwr(m1_nwr), .m1_req(m1_req),
        .m1_data_out(m1_data_out), .m1_ack(m1_ack),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_nwr(mem_nwr),
        .mem_req(mem_req), .mem_data_in(mem_data_in), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    nwr;
    } txn_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Controller model: acks ctl_delay cycles after seeing mem_req, holds ack until mem_req falls.
    int            ctl_delay = 0;
    int            ctl_cnt   = 0;
    bit            ctl_force = 1'b0;
    logic [31:0]   ctl_force_val = '0;
    logic [31:0]   ctl_rand = '0;
    logic [31:0]   ctl_last_rdata = '0;
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    logic [3:0]    log_nwr[$];
    int            log_rd = 0;

    always @(negedge clk) ctl_rand = ctl_force ? ctl_force_val : $urandom;

    always @(posedge clk) begin
        if (!mem_req) begin
            mem_ack <= 1'b0;
            ctl_cnt <= 0;
        end else if (!mem_ack) begin
            if (ctl_cnt >= ctl_delay) begin
                mem_ack        <= 1'b1;
                mem_data_in    <= ctl_rand;
                ctl_last_rdata <= ctl_rand;
                log_addr.push_back(mem_address);
                log_data.push_back(mem_data_out);
                log_nwr.push_back(mem_nwr);
            end else begin
                ctl_cnt <= ctl_cnt + 1;
            end
        end
    end

    // A new request must never start while the controller still acks the previous one.
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            n_checks++;
            if (mem_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL overlap: mem_req rose with mem_ack=%b, required 0", mem_ack);
            end
        end
        prev_req = mem_req;
    end

    // Reference model: issued requests per master plus the round-robin rule.
    txn_t iss0[$], iss1[$];
    bit   model_last = 1'b1;

    function automatic logic [3:0] rnd_nwr();
        return ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
    endfunction

    task automatic check_order();
        txn_t exp;
        int   k;
        while (iss0.size() > 0 || iss1.size() > 0) begin
            if (iss0.size() > 0 && iss1.size() > 0) k = model_last ? 0 : 1;
            else                                    k = (iss0.size() > 0) ? 0 : 1;
            exp = (k == 1) ? iss1.pop_front() : iss0.pop_front();
            model_last = (k == 1);
            n_checks++;
            if (log_rd >= log_addr.size()) begin
                n_fail++;
                $display("FAIL order: access %0d missing, required m%0d addr %h", log_rd, k, exp.addr);
            end else begin
                if (log_addr[log_rd] !== exp.addr || log_nwr[log_rd] !== exp.nwr ||
                    log_data[log_rd] !== exp.data) begin
                    n_fail++;
                    $display("FAIL order: access %0d got addr %h data %h nwr %h, required m%0d addr %h data %h nwr %h",
                             log_rd, log_addr[log_rd], log_data[log_rd], log_nwr[log_rd],
                             k, exp.addr, exp.data, exp.nwr);
                end
                log_rd++;
            end
        end
        n_checks++;
        if (log_addr.size() != log_rd) begin
            n_fail++;
            $display("FAIL access_count: got %0d accesses, required %0d", log_addr.size(), log_rd);
            log_rd = log_addr.size();
        end
    endtask

    task automatic master_txn(input int k, input logic [AW-1:0] addr, input logic [31:0] data,
                              input logic [3:0] nwr, input int hold, output int lat);
        logic [31:0] prev_dout, exp_dout, dout;
        txn_t        t;
        bit          got;
        @(negedge clk);
        prev_dout = (k == 1) ? m1_data_out : m0_data_out;
        t.addr = addr; t.data = data; t.nwr = nwr;
        if (k == 1) begin
            m1_address = addr; m1_data_in = data; m1_nwr = nwr; m1_req = 1'b1; iss1.push_back(t);
        end else begin
            m0_address = addr; m0_data_in = data; m0_nwr = nwr; m0_req = 1'b1; iss0.push_back(t);
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (((k == 1) ? m1_ack : m0_ack) === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout m%0d: no ack after %0d cycles, required ack", k, lat);
        end
        dout     = (k == 1) ? m1_data_out : m0_data_out;
        exp_dout = (nwr == 4'hF) ? ctl_last_rdata : prev_dout;
        n_checks++;
        if (dout !== exp_dout) begin
            n_fail++;
            $display("FAIL data_out m%0d: got %h, required %h", k, dout, exp_dout);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            n_checks++;
            if (((k == 1) ? m1_ack : m0_ack) !== 1'b1) begin
                n_fail++;
                $display("FAIL ack_hold m%0d: ack dropped while req high, required 1", k);
            end
        end
        if (k == 1) m1_req = 1'b0; else m0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (((k == 1) ? m1_ack : m0_ack) !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_clear m%0d: got 1 after req fell, required 0", k);
        end
    endtask

    task automatic wait_mem_req(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: mem_req never rose, required 1", name);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if (mem_req !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || mem_nwr !== 4'hF ||
            mem_address !== '0 || mem_data_out !== '0 || m0_data_out !== '0 || m1_data_out !== '0) begin
            n_fail++;
            $display("FAIL %s: req %b acks %b%b nwr %h addr %h wdata %h d0 %h d1 %h, required 0 00 f 0 0 0 0",
                     name, mem_req, m0_ack, m1_ack, mem_nwr, mem_address, mem_data_out,
                     m0_data_out, m1_data_out);
        end
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_reset();
        #2 nreset = 1'b0;
        #1 check_reset_values("reset_async");
        repeat (2) @(negedge clk);
        check_reset_values("reset_held");
        release_reset();
    endtask

    task automatic test_single_read();
        int lat;
        ctl_delay = 0;
        ctl_force = 1'b1;
        ctl_force_val = 32'hDEADBEEF;
        master_txn(0, 23'h000123, 32'h0, 4'hF, 3, lat);
        ctl_force = 1'b0;
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required 3", lat);
        end
        n_checks++;
        if (m0_data_out !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_read: m0_data_out %h, required deadbeef", m0_data_out);
        end
        check_order();
    endtask

    task automatic test_tie();
        int l0, l1;
        nreset = 1'b0;
        release_reset();
        ctl_delay = $urandom_range(0, 3);
        fork
            master_txn(0, AW'($urandom), $urandom, rnd_nwr(), 0, l0);
            master_txn(1, AW'($urandom), $urandom, rnd_nwr(), 0, l1);
        join
        check_order();
    endtask

    task automatic test_round_robin();
        ctl_delay = $urandom_range(0, 3);
        fork
            begin : mst0
                int l;
                for (int i = 0; i < 4; i++) master_txn(0, AW'($urandom), $urandom, rnd_nwr(), 0, l);
            end
            begin : mst1
                int l;
                for (int i = 0; i < 4; i++) master_txn(1, AW'($urandom), $urandom, rnd_nwr(), 0, l);
            end
        join
        check_order();
    endtask

    task automatic test_byte_write();
        int lat;
        ctl_delay = 1;
        master_txn(1, AW'($urandom), 32'hA5A5A5A5, 4'b1100, 0, lat);
        check_order();
    endtask

    task automatic test_slow_controller();
        txn_t          t;
        logic [AW-1:0] a;
        logic [31:0]   prev_dout;
        bit            got;
        int            pulses;
        ctl_delay = 10;
        a = AW'($urandom);
        @(negedge clk);
        m0_address = a; m0_data_in = $urandom; m0_nwr = 4'hF; m0_req = 1'b1;
        t.addr = a; t.data = m0_data_in; t.nwr = 4'hF; iss0.push_back(t);
        wait_mem_req("slow_grant");
        m0_address = ~a; m0_data_in = ~m0_data_in; m0_nwr = 4'h0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (mem_address !== a || mem_nwr !== 4'hF) begin
                n_fail++;
                $display("FAIL slow_latch: mem_address %h nwr %h, required %h f", mem_address, mem_nwr, a);
            end
        end
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (m0_ack === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (!got || m0_data_out !== ctl_last_rdata) begin
            n_fail++;
            $display("FAIL slow_read: ack %b data %h, required 1 %h", got, m0_data_out, ctl_last_rdata);
        end
        m0_req = 1'b0;
        @(negedge clk);
        check_order();

        // Requester gives up mid-access: the write still completes with a single ack cycle.
        prev_dout = m0_data_out;
        a = AW'($urandom);
        m0_address = a; m0_data_in = $urandom; m0_nwr = 4'b0000; m0_req = 1'b1;
        t.addr = a; t.data = m0_data_in; t.nwr = 4'b0000; iss0.push_back(t);
        wait_mem_req("drop_grant");
        @(negedge clk);
        m0_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (m0_ack === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL drop_req_ack: ack high %0d cycles, required 1", pulses);
        end
        n_checks++;
        if (m0_data_out !== prev_dout) begin
            n_fail++;
            $display("FAIL drop_req_write: m0_data_out %h, required %h", m0_data_out, prev_dout);
        end
        check_order();
    endtask

    task automatic test_reset_in_busy();
        int lat;
        ctl_delay = 10;
        @(negedge clk);
        m0_address = AW'($urandom); m0_nwr = 4'hF; m0_req = 1'b1;
        wait_mem_req("rst_busy_grant");
        repeat (2) @(negedge clk);
        #2 nreset = 1'b0;
        #1 check_reset_values("reset_in_busy");
        m0_req = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset_in_busy_held");
        release_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (log_addr.size() != log_rd || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abandon: accesses %0d acks %b%b, required %0d 00",
                     log_addr.size(), m0_ack, m1_ack, log_rd);
        end
        ctl_delay = 0;
        master_txn(0, AW'($urandom), $urandom, 4'hF, 0, lat);
        check_order();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_round_robin();
        test_byte_write();
        test_slow_controller();
        test_reset_in_busy();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
